// File: rtl/mc_request_intake_pkg.sv
// Shared types and field widths for the memory-controller request intake.
package mc_request_intake_pkg;

   localparam int ADDR_WIDTH  = 36;
   localparam int MEMOP_WIDTH = 12;
   localparam int TIME_WIDTH  = 12;
   localparam int DATA_WIDTH  = TIME_WIDTH + MEMOP_WIDTH + ADDR_WIDTH;
   localparam int CMD_WIDTH   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } intake_state_t;

   typedef enum logic [CMD_WIDTH-1:0] {
      MEM_READ   = 2'd0,
      MEM_WRITE  = 2'd1,
      MEM_IFETCH = 2'd2
   } memop_e;

   typedef struct packed {
      logic [TIME_WIDTH-1:0] req_time;
      memop_e                cmd;
      logic [ADDR_WIDTH-1:0] addr;
   } trace_req_t;

   // The whole command field takes part, so stray high bits make a word illegal.
   function automatic logic cmd_is_legal(input logic [MEMOP_WIDTH-1:0] raw);
      return raw <= MEMOP_WIDTH'(2);
   endfunction

endpackage

// File: rtl/mc_request_intake_if.sv
// Parser word handshake and scheduler dequeue port of the request intake.
interface mc_request_intake_if;
   import mc_request_intake_pkg::*;

   logic                  data_rdy;
   logic [DATA_WIDTH-1:0] data_read;
   logic                  data_req;
   logic                  deq_valid;
   logic                  deq_ready;
   logic [CMD_WIDTH-1:0]  deq_cmd;
   logic [ADDR_WIDTH-1:0] deq_addr;
   logic [TIME_WIDTH-1:0] deq_time;

   modport master (
      output data_rdy, data_read, deq_ready,
      input  data_req, deq_valid, deq_cmd, deq_addr, deq_time
   );

   modport slave (
      input  data_rdy, data_read, deq_ready,
      output data_req, deq_valid, deq_cmd, deq_addr, deq_time
   );

endinterface

// File: rtl/mc_req_fifo.sv
// In-order circular request buffer with occupancy count; DEPTH must be a power of two.
module mc_req_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full buffer still takes a word when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mc_request_intake.sv
// Receives trace words from the parser, queues them in order and releases each
// to the DRAM scheduler once the cycle count reaches its timestamp.
//
//   state | meaning
//   IDLE  | one cycle after reset, not yet requesting
//   REQ   | requesting words while the queue has room; watches for end of trace
//   DRAIN | trace ended, emptying the queue
//   DONE  | queue drained, shutdown held until reset
module mc_request_intake
   import mc_request_intake_pkg::*;
#(
   parameter int QUEUE_DEPTH = 16,
   parameter int EOT_TIMEOUT = 8
) (
   input  logic                         clock,
   input  logic                         reset_n,
   mc_request_intake_if.slave           bus,
   output logic                         shutdown,
   output logic [63:0]                  cycle,
   output logic [$clog2(QUEUE_DEPTH):0] q_count,
   output logic [15:0]                  bad_cmd_cnt
);
   localparam int TW = $clog2(EOT_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(EOT_TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(1);

   intake_state_t          state;
   intake_state_t          state_nxt;
   logic [TW-1:0]          tmo_cnt;
   logic [TW-1:0]          tmo_nxt;
   logic                   rdy_q;
   logic                   word_rise;
   logic                   accept;
   logic                   cmd_legal;
   logic                   push;
   logic                   pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [TIME_WIDTH-1:0]  raw_time;
   logic [MEMOP_WIDTH-1:0] raw_cmd;
   logic [ADDR_WIDTH-1:0]  raw_addr;
   trace_req_t             in_req;
   trace_req_t             head;

   assign raw_time  = bus.data_read[DATA_WIDTH-1 -: TIME_WIDTH];
   assign raw_cmd   = bus.data_read[ADDR_WIDTH +: MEMOP_WIDTH];
   assign raw_addr  = bus.data_read[ADDR_WIDTH-1:0];
   assign cmd_legal = cmd_is_legal(raw_cmd);
   assign in_req    = '{req_time: raw_time,
                        cmd:      memop_e'(raw_cmd[CMD_WIDTH-1:0]),
                        addr:     raw_addr};

   // A held data_rdy is a single word; only its rising edge counts.
   assign word_rise = bus.data_rdy && !rdy_q;
   assign accept    = word_rise && (state == REQ);
   assign push      = accept && cmd_legal;

   assign bus.data_req  = (state == REQ) && !fifo_full;
   assign bus.deq_valid = !fifo_empty && (cycle >= 64'(head.req_time));
   assign pop           = bus.deq_valid && bus.deq_ready;
   assign bus.deq_cmd   = fifo_empty ? 2'b00 : head.cmd;
   assign bus.deq_addr  = fifo_empty ? '0 : head.addr;
   assign bus.deq_time  = fifo_empty ? '0 : head.req_time;
   assign shutdown      = (state == DONE);

   mc_req_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH ($bits(trace_req_t))
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .din     (in_req),
      .pop     (pop),
      .dout    (head),
      .count   (q_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         tmo_cnt <= TMO_LOAD;
      end else begin
         state   <= state_nxt;
         tmo_cnt <= tmo_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tmo_nxt   = tmo_cnt;
      case (state)
         IDLE: begin
            state_nxt = REQ;
            tmo_nxt   = TMO_LOAD;
         end
         REQ: begin
            // Silence only counts while a word is actually being asked for.
            if (word_rise) begin
               tmo_nxt = TMO_LOAD;
            end else if (bus.data_req) begin
               if (tmo_cnt == TMO_LAST) begin
                  state_nxt = DRAIN;
               end else begin
                  tmo_nxt = tmo_cnt - TMO_LAST;
               end
            end
         end
         DRAIN: begin
            if (fifo_empty) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdy_q       <= 1'b0;
         cycle       <= '0;
         bad_cmd_cnt <= '0;
      end else begin
         rdy_q <= bus.data_rdy;
         cycle <= cycle + 64'd1;
         if (accept && !cmd_legal && (bad_cmd_cnt != 16'hFFFF)) begin
            bad_cmd_cnt <= bad_cmd_cnt + 16'd1;
         end
      end
   end

endmodule
